capture_sequencer: RTL

Sequences one acquisition frame for the sample-capture path. Accepts an arm command from the MCU interface and runs the external 18-bit window counter twice: first for the pre-trigger window, then for the post-trigger window. Between the two windows it waits for a trigger event, or forces one in auto mode. It drives the sample-memory write strobe and the circular write address, and latches the address of the trigger sample for readout.

---
 rtl/capture_sequencer_pkg.sv | 13 +
 rtl/capture_sequencer_auto_trig_timer.sv | 19 +
 rtl/capture_sequencer.sv | 81 ++++++++
 3 files changed

// File: rtl/capture_sequencer_pkg.sv
// capture_sequencer_pkg: shared state encoding and default address width
package capture_sequencer_pkg;
  localparam int ADDR_W_DEF = 18;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRE_CLR  = 3'd1,
    S_PRE      = 3'd2,
    S_ARMED    = 3'd3,
    S_POST_CLR = 3'd4,
    S_POST     = 3'd5,
    S_DONE     = 3'd6
  } state_t;
endpackage

// File: rtl/capture_sequencer_auto_trig_timer.sv
// auto_trig_timer: counts enabled sample strobes and pulses on the last one before a forced trigger
module auto_trig_timer #(
  parameter int AUTO_W = 20,
  parameter logic [AUTO_W-1:0] AUTO_LEN = 20'd100000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [AUTO_W-1:0] cnt;
  assign tc = en && cnt == AUTO_LEN - 1'b1;
  // timeout count, restarted on arm and after each terminal pulse
  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt <= '0;
    else if (clr || tc) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer: runs the pre-trigger and post-trigger windows of one acquisition frame
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int AUTO_W = 20,
  parameter logic [AUTO_W-1:0] AUTO_LEN = 20'd100000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLK_EN,
  input  logic              START,
  input  logic              ABORT,
  input  logic              AUTO_MODE,
  input  logic              TRIG_IN,
  input  logic [17:0]       PRE_DATA,
  input  logic [17:0]       POST_DATA,
  input  logic              WIN_READY,
  output logic [17:0]       WIN_DATA,
  output logic              WIN_START,
  output logic              WIN_EVENT,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [ADDR_W-1:0] TRIG_ADDR,
  output logic              BUSY,
  output logic              DONE,
  output logic              TRIG_FORCED,
  output logic [2:0]        STATE
);
  state_t state, nxt;
  logic arm, hit, tmo, fire;
  assign STATE     = state;
  assign arm       = START && (state == S_IDLE || state == S_DONE);
  assign WR_EN     = CLK_EN && !ABORT && (state inside {S_PRE, S_ARMED, S_POST_CLR, S_POST});
  assign WIN_EVENT = CLK_EN && (state == S_PRE || state == S_POST);
  assign hit       = state == S_ARMED && CLK_EN && TRIG_IN;
  assign fire      = hit || tmo;
  auto_trig_timer #(.AUTO_W(AUTO_W), .AUTO_LEN(AUTO_LEN)) u_tmr (
    .CLK (CLK),
    .RST (RST),
    .clr (arm),
    .en  (state == S_ARMED && CLK_EN && AUTO_MODE),
    .tc  (tmo)
  );
  // next state: abort first, then arm, then window/trigger progression
  always_comb
    nxt = ABORT                          ? S_IDLE     :
          arm                            ? S_PRE_CLR  :
          state == S_PRE_CLR             ? S_PRE      :
          state == S_PRE && WIN_READY    ? S_ARMED    :
          state == S_ARMED && fire       ? S_POST_CLR :
          state == S_POST_CLR            ? S_POST     :
          state == S_POST && WIN_READY   ? S_DONE     : state;
  // state register, registered window controls, write address and trigger latch
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state       <= S_IDLE;
      WIN_DATA    <= '0;
      WIN_START   <= 1'b0;
      WR_ADDR     <= '0;
      TRIG_ADDR   <= '0;
      TRIG_FORCED <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
    end else begin
      state     <= nxt;
      WIN_START <= nxt inside {S_PRE, S_ARMED, S_POST};
      BUSY      <= !(nxt inside {S_IDLE, S_DONE});
      DONE      <= nxt == S_DONE;
      if (arm && !ABORT) begin
        WIN_DATA    <= PRE_DATA;
        WR_ADDR     <= '0;
        TRIG_FORCED <= 1'b0;
      end else if (WR_EN) WR_ADDR <= WR_ADDR + 1'b1;
      if (fire && !ABORT) begin
        TRIG_ADDR   <= WR_ADDR;
        WIN_DATA    <= POST_DATA;
        TRIG_FORCED <= !hit;
      end
    end
endmodule
